// File: rtl/hack_pkg.sv
// Shared definitions for the Hack instruction-store loader: word geometry,
// frame layout constants and the loader state encoding.
package hack_pkg;

  localparam int HACK_ADDR_W    = 15;
  localparam int HACK_DATA_W    = 16;
  localparam int HACK_MAX_WORDS = 32768;

  localparam int FRAME_LEN_BYTES      = 2;
  localparam int FRAME_BYTES_PER_WORD = 2;
  localparam logic [7:0] FRAME_SUM_OK = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

  // A session spans every state that consumes frame bytes.
  function automatic logic in_session(input loader_state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CSUM);
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte stream link (valid/ready) from the host into the loader.
interface rom_loader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rom_loader_csum.sv
// 8-bit running sum of frame bytes; zero_next reports whether adding the
// current byte would bring the total to zero.
module rom_loader_csum
  import hack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] add_data,
  output logic       zero_next
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;
  logic [7:0] sum_plus;

  assign sum_plus  = sum_q + add_data;
  assign zero_next = (sum_plus == FRAME_SUM_OK);

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = 8'h00;
    end else if (add_en) begin
      sum_d = sum_plus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Frames a host byte stream into 16-bit Hack words and writes them into the
// instruction memory, holding the CPU in reset until a load verifies.
module rom_loader
  import hack_pkg::*;
#(
  parameter int          ADDR_W    = HACK_ADDR_W,
  parameter int          DATA_W    = HACK_DATA_W,
  parameter int unsigned MAX_WORDS = HACK_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  rom_loader_if.slave       in_if,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_e     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              accept;
  logic              csum_clear;
  logic              csum_zero;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   words_inc;

  assign busy         = in_session(state_q);
  assign in_if.ready  = busy;
  assign accept       = busy && in_if.valid;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign cpu_reset    = (state_q != IDLE) && (state_q != DONE);
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = words_q;

  assign len_full  = {len_q[15:8], in_if.data};
  assign words_inc = words_q + 1'b1;

  rom_loader_csum u_csum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (csum_clear),
    .add_en    (accept),
    .add_data  (in_if.data),
    .zero_next (csum_zero)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    hi_d       = hi_q;
    words_d    = words_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    csum_clear = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_HI;
          words_d    = '0;
          csum_clear = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_if.data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if (32'(len_full) > MAX_WORDS) begin
            state_d = ERR;
          end else if (len_full == 16'h0000) begin
            state_d = CSUM;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          hi_d    = in_if.data;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        // The write address is the pre-increment count, so word k lands at k.
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = words_q[ADDR_W-1:0];
          wr_data_d = DATA_W'({hi_q, in_if.data});
          words_d   = words_inc;
          state_d   = (32'(words_inc) == 32'(len_q)) ? CSUM : DATA_HI;
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = csum_zero ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      hi_q      <= '0;
      words_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      words_q   <= words_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized frame-level bench for rom_loader: frames are parsed by a
// byte-level model and compared with observed memory writes and status.
module tb_rom_loader;

  localparam int AW = 6;
  localparam int MW = 64;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  rom_loader_if in_if ();

  rom_loader #(
    .ADDR_W    (AW),
    .DATA_W    (16),
    .MAX_WORDS (MW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_if        (in_if.slave),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  wr_t got_wr[$];
  int  lo_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe together with the cycle it was visible in.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      got_wr.push_back('{int'(wr_addr), int'(wr_data), cyc});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input bq_t f);
    if (f.size() < 2) return 0;
    return (int'(f[0]) << 8) | int'(f[1]);
  endfunction

  // Builds a frame with n random words; the checksum is the negated byte sum.
  function automatic bq_t make_frame(input int n, input bit good);
    bq_t f;
    logic [7:0] s;
    s = 8'h00;
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    if (n <= MW) begin
      for (int i = 0; i < 2 * n; i++) f.push_back(8'($urandom));
      foreach (f[i]) s = s + f[i];
      f.push_back(good ? 8'(-s) : 8'(-s + 8'h01));
    end
    return f;
  endfunction

  task automatic applyStimulus(input bq_t f, input int nsend, input bit throttle, input bit poke_start);
    int n;
    int w;
    n = frame_len(f);
    got_wr.delete();
    lo_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_on_start", busy, 1);
    checkOutput("cpu_reset_on_start", cpu_reset, 1);
    checkOutput("done_cleared", done, 0);
    checkOutput("error_cleared", error, 0);
    for (int i = 0; i < nsend; i++) begin
      if (throttle) repeat ($urandom_range(0, 3)) @(negedge clk);
      w = 0;
      while (in_if.ready !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (in_if.ready !== 1'b1) begin
        checkOutput("ready_timeout", in_if.ready, 1);
        break;
      end
      in_if.valid = 1'b1;
      in_if.data  = f[i];
      if (poke_start && i == nsend / 2) start = 1'b1;
      if (i >= 2 && i < 2 + 2 * n && ((i - 2) % 2) == 1) lo_cyc.push_back(cyc);
      @(negedge clk);
      in_if.valid = 1'b0;
      in_if.data  = 8'($urandom);
      start       = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  // Reference: parse the frame by its rules and compare the whole session.
  task automatic verify(input bq_t f, input string tag);
    int n;
    int nw;
    bit ok;
    logic [7:0] s;
    int m;
    n = frame_len(f);
    if (n > MW) begin
      ok = 1'b0;
      nw = 0;
    end else begin
      s = 8'h00;
      for (int i = 0; i < 2 + 2 * n + 1; i++) s = s + f[i];
      ok = (s == 8'h00);
      nw = n;
    end
    checkOutput($sformatf("%s.n_writes", tag), got_wr.size(), nw);
    m = (got_wr.size() < nw) ? got_wr.size() : nw;
    for (int i = 0; i < m; i++) begin
      checkOutput($sformatf("%s.wr_addr[%0d]", tag, i), got_wr[i].addr, i);
      checkOutput($sformatf("%s.wr_data[%0d]", tag, i), got_wr[i].data,
                  (int'(f[2 + 2 * i]) << 8) | int'(f[3 + 2 * i]));
      if (i < lo_cyc.size())
        checkOutput($sformatf("%s.wr_latency[%0d]", tag, i), got_wr[i].cyc, lo_cyc[i] + 1);
    end
    checkOutput($sformatf("%s.done", tag), done, ok);
    checkOutput($sformatf("%s.error", tag), error, !ok);
    checkOutput($sformatf("%s.cpu_reset", tag), cpu_reset, !ok);
    checkOutput($sformatf("%s.busy", tag), busy, 0);
    checkOutput($sformatf("%s.in_ready", tag), in_if.ready, 0);
    checkOutput($sformatf("%s.words_loaded", tag), words_loaded, nw);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput($sformatf("%s.in_ready", tag), in_if.ready, 0);
    checkOutput($sformatf("%s.wr_en", tag), wr_en, 0);
    checkOutput($sformatf("%s.wr_addr", tag), wr_addr, 0);
    checkOutput($sformatf("%s.wr_data", tag), wr_data, 0);
    checkOutput($sformatf("%s.cpu_reset", tag), cpu_reset, 0);
    checkOutput($sformatf("%s.busy", tag), busy, 0);
    checkOutput($sformatf("%s.done", tag), done, 0);
    checkOutput($sformatf("%s.error", tag), error, 0);
    checkOutput($sformatf("%s.words_loaded", tag), words_loaded, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bq_t basic;
    bq_t bad;
    bq_t f;
    int  n;

    in_if.valid = 1'b0;
    in_if.data  = 8'h00;
    start       = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Two words 1234, ABCD; 0x40 is the negation of their byte sum 0xC0.
    basic = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    applyStimulus(basic, basic.size(), 1'b0, 1'b0);
    verify(basic, "basic");

    bad = basic;
    bad[6] = 8'h41;
    applyStimulus(bad, bad.size(), 1'b0, 1'b0);
    verify(bad, "bad_csum");

    f = '{8'h00, 8'h00, 8'h00};
    applyStimulus(f, f.size(), 1'b0, 1'b0);
    verify(f, "zero_len");

    f = '{8'h80, 8'h01};
    applyStimulus(f, f.size(), 1'b0, 1'b0);
    verify(f, "oversize");
    for (int i = 0; i < 5; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = 8'($urandom);
      @(negedge clk);
    end
    in_if.valid = 1'b0;
    checkOutput("oversize.ignored_writes", got_wr.size(), 0);
    checkOutput("oversize.still_error", error, 1);
    checkOutput("oversize.still_not_ready", in_if.ready, 0);

    applyStimulus(basic, basic.size(), 1'b1, 1'b1);
    verify(basic, "throttled");

    applyStimulus(basic, 3, 1'b0, 1'b0);
    checkOutput("midload.busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midload_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(basic, basic.size(), 1'b0, 1'b0);
    verify(basic, "after_rst");

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(0, 10);
      f = make_frame(n, ($urandom_range(0, 3) != 0));
      applyStimulus(f, f.size(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      verify(f, $sformatf("rand%0d", t));
    end

    f = make_frame(MW, 1'b1);
    applyStimulus(f, f.size(), 1'b0, 1'b0);
    verify(f, "max_words");

    f = make_frame(MW + 1, 1'b1);
    applyStimulus(f, f.size(), 1'b0, 1'b0);
    verify(f, "max_plus_one");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
